vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/sync_delay_line.sv | 43 ++++
 rtl/vga_sync_gen.sv | 196 +++++++++++++++++++
 tb/tb_vga_sync_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
//
// Contents:
//   - Default 640x480 @ 60 Hz timing constants (pixels / lines).
//   - Colour channel width and counter width.
//   - sync_bits_t: the {hsync, vsync, active} bundle carried by the delay line.
//   - SyncBitsIdle: delay-line contents while blanked/in reset (syncs
//     deasserted high, not active).
//   - in_window(): half-open range test used for the raw sync decodes.
package vga_timing_pkg;

  localparam int unsigned DefTotalCols    = 800;
  localparam int unsigned DefTotalRows    = 525;
  localparam int unsigned DefActiveCols   = 640;
  localparam int unsigned DefActiveRows   = 480;
  localparam int unsigned DefHFrontPorch  = 16;
  localparam int unsigned DefHSyncWidth   = 96;
  localparam int unsigned DefVFrontPorch  = 10;
  localparam int unsigned DefVSyncWidth   = 2;
  localparam int unsigned DefVideoDelay   = 2;
  localparam int unsigned MaxVideoDelay   = 7;

  localparam int unsigned ColorWidth      = 4;
  localparam int unsigned CountWidth      = 10;
  localparam int unsigned FrameCountWidth = 8;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_bits_t;

  localparam sync_bits_t SyncBitsIdle = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

  // True when lo <= pos < hi.
  function automatic logic in_window(input logic [CountWidth-1:0] pos,
                                     input int unsigned           lo,
                                     input int unsigned           hi);
    return (32'(pos) >= lo) && (32'(pos) < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Resettable shift register for the {hsync, vsync, active} bundle.
//
// Ports:
//   clk   in   pixel clock
//   rst   in   asynchronous active-high reset; all stages load SyncBitsIdle
//   din   in   sync_bits_t entering the line
//   dout  out  din delayed by Depth clock cycles (Depth = 0 is a plain wire)
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  sync_bits_t din,
  output sync_bits_t dout
);

  if (Depth == 0) begin : gen_wire
    // Clock and reset have no load in the zero-latency configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : gen_shift
    sync_bits_t stage_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(Depth); i++) begin
          stage_q[i] <= SyncBitsIdle;
        end
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < int'(Depth); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign dout = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA transmitter timing generator.
//
// Produces free-running column/row counters for the renderer, per-frame
// strobes for game logic, and latency-aligned active-low syncs plus blanked
// RGB for the connector. The renderer returns colour VIDEO_DELAY cycles after
// it sees a counter value; syncs and the active flag are delayed to match,
// then everything passes one output register together.
//
// Ports:
//   i_Clk          in   pixel clock
//   i_Rst          in   asynchronous active-high reset
//   o_Col_Count    out  current pixel column (undelayed)
//   o_Row_Count    out  current line (undelayed)
//   o_Active       out  counters inside the visible area (undelayed)
//   o_Frame_Start  out  one-cycle strobe at (col 0, row 0)
//   o_Frame_Tick   out  one-cycle strobe at (col 0, row ACTIVE_ROWS)
//   o_Frame_Count  out  frames completed, mod 256
//   i_*_Video      in   renderer colour, valid VIDEO_DELAY cycles after counters
//   o_HSync/VSync  out  active-low syncs, aligned to o_*_Video
//   o_*_Video      out  colour forced to zero outside the active area
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS    = DefTotalCols,
  parameter int unsigned TOTAL_ROWS    = DefTotalRows,
  parameter int unsigned ACTIVE_COLS   = DefActiveCols,
  parameter int unsigned ACTIVE_ROWS   = DefActiveRows,
  parameter int unsigned H_FRONT_PORCH = DefHFrontPorch,
  parameter int unsigned H_SYNC_WIDTH  = DefHSyncWidth,
  parameter int unsigned V_FRONT_PORCH = DefVFrontPorch,
  parameter int unsigned V_SYNC_WIDTH  = DefVSyncWidth,
  parameter int unsigned VIDEO_DELAY   = DefVideoDelay
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  output logic [CountWidth-1:0]      o_Col_Count,
  output logic [CountWidth-1:0]      o_Row_Count,
  output logic                       o_Active,
  output logic                       o_Frame_Start,
  output logic                       o_Frame_Tick,
  output logic [FrameCountWidth-1:0] o_Frame_Count,
  input  logic [ColorWidth-1:0]      i_Red_Video,
  input  logic [ColorWidth-1:0]      i_Grn_Video,
  input  logic [ColorWidth-1:0]      i_Blu_Video,
  output logic                       o_HSync,
  output logic                       o_VSync,
  output logic [ColorWidth-1:0]      o_Red_Video,
  output logic [ColorWidth-1:0]      o_Grn_Video,
  output logic [ColorWidth-1:0]      o_Blu_Video
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : gen_h_err
    $error("vga_sync_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : gen_v_err
    $error("vga_sync_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
  end
  if (VIDEO_DELAY > MaxVideoDelay) begin : gen_delay_err
    $error("vga_sync_gen: VIDEO_DELAY must be in 0..7");
  end
  if ((TOTAL_COLS > (1 << CountWidth)) || (TOTAL_ROWS > (1 << CountWidth)) ||
      (TOTAL_COLS == 0) || (TOTAL_ROWS == 0)) begin : gen_width_err
    $error("vga_sync_gen: totals must be 1..2**CountWidth");
  end

  localparam int unsigned HSyncStart = ACTIVE_COLS + H_FRONT_PORCH;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC_WIDTH;
  localparam int unsigned VSyncStart = ACTIVE_ROWS + V_FRONT_PORCH;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC_WIDTH;

  localparam logic [CountWidth-1:0] LastCol    = CountWidth'(TOTAL_COLS - 1);
  localparam logic [CountWidth-1:0] LastRow    = CountWidth'(TOTAL_ROWS - 1);
  localparam logic [CountWidth-1:0] ActiveCols = CountWidth'(ACTIVE_COLS);
  localparam logic [CountWidth-1:0] ActiveRows = CountWidth'(ACTIVE_ROWS);

  // Strobe/active registers hold the decode of (0,0) while in reset so they
  // stay consistent with the cleared counters.
  localparam logic ActiveAtOrigin = (ACTIVE_COLS > 0) && (ACTIVE_ROWS > 0);
  localparam logic TickAtOrigin   = (ACTIVE_ROWS == 0);

  // ---------------------------------------------------------------------------
  // Pixel counters and undelayed decodes
  // ---------------------------------------------------------------------------
  logic [CountWidth-1:0] col_q, col_d;
  logic [CountWidth-1:0] row_q, row_d;
  logic                  active_q, active_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  col_wrap;

  always_comb begin
    col_wrap = (col_q == LastCol);
    col_d    = col_wrap ? '0 : col_q + CountWidth'(1);
    row_d    = row_q;
    if (col_wrap) begin
      row_d = (row_q == LastRow) ? '0 : row_q + CountWidth'(1);
    end
    // Decode from the next-state values so the registered flags line up with
    // the registered counters in the same cycle.
    active_d      = (col_d < ActiveCols) && (row_d < ActiveRows);
    frame_start_d = (col_d == '0) && (row_d == '0);
    frame_tick_d  = (col_d == '0) && (row_d == ActiveRows);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      col_q         <= '0;
      row_q         <= '0;
      active_q      <= ActiveAtOrigin;
      frame_start_q <= 1'b1;
      frame_tick_q  <= TickAtOrigin;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter: counts completed visible frames
  // ---------------------------------------------------------------------------
  logic [FrameCountWidth-1:0] frame_count_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      frame_count_q <= '0;
    end else if (frame_tick_q) begin
      frame_count_q <= frame_count_q + FrameCountWidth'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Raw syncs, delay line and output register
  // ---------------------------------------------------------------------------
  sync_bits_t sync_raw;
  sync_bits_t sync_dly;

  // VSync is decoded from the row alone, so it only moves on the column wrap.
  always_comb begin
    sync_raw        = SyncBitsIdle;
    sync_raw.hsync  = !in_window(col_q, HSyncStart, HSyncEnd);
    sync_raw.vsync  = !in_window(row_q, VSyncStart, VSyncEnd);
    sync_raw.active = active_q;
  end

  sync_delay_line #(
    .Depth (VIDEO_DELAY)
  ) u_sync_delay_line (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .din  (sync_raw),
    .dout (sync_dly)
  );

  logic                  hsync_q;
  logic                  vsync_q;
  logic [ColorWidth-1:0] red_q;
  logic [ColorWidth-1:0] grn_q;
  logic [ColorWidth-1:0] blu_q;

  // Colour is gated by the delayed active bit so blanking does not depend on
  // what the renderer drives outside the visible area.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      hsync_q <= sync_dly.hsync;
      vsync_q <= sync_dly.vsync;
      red_q   <= i_Red_Video & {ColorWidth{sync_dly.active}};
      grn_q   <= i_Grn_Video & {ColorWidth{sync_dly.active}};
      blu_q   <= i_Blu_Video & {ColorWidth{sync_dly.active}};
    end
  end

  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Active      = active_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Frame_Tick  = frame_tick_q;
  assign o_Frame_Count = frame_count_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Red_Video   = red_q;
  assign o_Grn_Video   = grn_q;
  assign o_Blu_Video   = blu_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Two instances share clock and reset:
//   s_* : reduced timing (20x10 total, 12x6 active, hsync cols 14..16,
//         vsync rows 7..8, delay 2) so whole frames fit the cycle budget.
//   d_* : default 640x480 timing, checked over the first lines.
// Cycle index k counts sampled cycles after reset release (k = 0 is the
// cycle before the first post-release clock edge); at cycle k the counters
// show pixel k and the syncs/colour show pixel k-3.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Reduced-timing instance
  logic [9:0] s_col, s_row;
  logic       s_act, s_fs, s_ft, s_hs, s_vs;
  logic [7:0] s_fc;
  logic [3:0] s_r, s_g, s_b;
  logic [3:0] s_ri, s_gi, s_bi;
  logic [3:0] s_g_p1 = '0, s_g_p2 = '0, s_b_p1 = '0, s_b_p2 = '0;

  // Default-timing instance
  logic [9:0] d_col, d_row;
  logic       d_act, d_fs, d_ft, d_hs, d_vs;
  logic [7:0] d_fc;
  logic [3:0] d_r, d_g, d_b;
  logic [3:0] d_ri, d_gi, d_bi;
  logic [3:0] d_g_p1 = '0, d_g_p2 = '0;

  vga_sync_gen #(
    .TOTAL_COLS    (20),
    .TOTAL_ROWS    (10),
    .ACTIVE_COLS   (12),
    .ACTIVE_ROWS   (6),
    .H_FRONT_PORCH (2),
    .H_SYNC_WIDTH  (3),
    .V_FRONT_PORCH (1),
    .V_SYNC_WIDTH  (2),
    .VIDEO_DELAY   (2)
  ) dut_s (
    .i_Clk (clk), .i_Rst (rst),
    .o_Col_Count (s_col), .o_Row_Count (s_row), .o_Active (s_act),
    .o_Frame_Start (s_fs), .o_Frame_Tick (s_ft), .o_Frame_Count (s_fc),
    .i_Red_Video (s_ri), .i_Grn_Video (s_gi), .i_Blu_Video (s_bi),
    .o_HSync (s_hs), .o_VSync (s_vs),
    .o_Red_Video (s_r), .o_Grn_Video (s_g), .o_Blu_Video (s_b)
  );

  vga_sync_gen dut_d (
    .i_Clk (clk), .i_Rst (rst),
    .o_Col_Count (d_col), .o_Row_Count (d_row), .o_Active (d_act),
    .o_Frame_Start (d_fs), .o_Frame_Tick (d_ft), .o_Frame_Count (d_fc),
    .i_Red_Video (d_ri), .i_Grn_Video (d_gi), .i_Blu_Video (d_bi),
    .o_HSync (d_hs), .o_VSync (d_vs),
    .o_Red_Video (d_r), .o_Grn_Video (d_g), .o_Blu_Video (d_b)
  );

  // Renderer models: red constant F, green = col[3:0], blue = row[3:0] (small)
  // or 0 (default), each with a 2-cycle latency.
  always @(posedge clk) begin
    s_g_p1 <= s_col[3:0];
    s_g_p2 <= s_g_p1;
    s_b_p1 <= s_row[3:0];
    s_b_p2 <= s_b_p1;
    d_g_p1 <= d_col[3:0];
    d_g_p2 <= d_g_p1;
  end
  assign s_gi = s_g_p2;
  assign s_bi = s_b_p2;
  assign d_gi = d_g_p2;

  initial begin
    s_ri = 4'hF;
    d_ri = 4'hF;
    d_bi = 4'h0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cur++;
  endtask

  typedef struct {
    bit dflt;
    int k;
    int col, row;
    bit act, fs, ft;
    int fc;
    bit hs, vs;
    int red, grn;
  } vec_t;

  function automatic vec_t mk(bit dflt, int k, int col, int row, bit act, bit fs, bit ft,
                              int fc, bit hs, bit vs, int red, int grn);
    vec_t v;
    v.dflt = dflt; v.k = k; v.col = col; v.row = row; v.act = act; v.fs = fs;
    v.ft = ft; v.fc = fc; v.hs = hs; v.vs = vs; v.red = red; v.grn = grn;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int hs_lo, vs_lo, red_on, fs_n, ft_n, fs_k, ft_k, falls, fall0, fall1;
    int pk, pc, pr;
    bit pa, prev_hs;

    //          dflt k     col  row act fs ft fc hs vs red grn
    vecs.push_back(mk(0,    0,   0, 0, 1, 1, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(1,    0,   0, 0, 1, 1, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(1,    3,   3, 0, 1, 0, 0, 0, 1, 1, 15,  0));
    vecs.push_back(mk(0,   11,  11, 0, 1, 0, 0, 0, 1, 1, 15,  8));
    vecs.push_back(mk(0,   12,  12, 0, 0, 0, 0, 0, 1, 1, 15,  9));
    vecs.push_back(mk(0,   14,  14, 0, 0, 0, 0, 0, 1, 1, 15, 11));
    vecs.push_back(mk(0,   15,  15, 0, 0, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(0,   16,  16, 0, 0, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(0,   17,  17, 0, 0, 0, 0, 0, 0, 1,  0,  0));
    vecs.push_back(mk(0,   19,  19, 0, 0, 0, 0, 0, 0, 1,  0,  0));
    vecs.push_back(mk(0,   20,   0, 1, 1, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(0,   23,   3, 1, 1, 0, 0, 0, 1, 1, 15,  0));
    vecs.push_back(mk(0,   24,   4, 1, 1, 0, 0, 0, 1, 1, 15,  1));
    vecs.push_back(mk(0,  114,  14, 5, 0, 0, 0, 0, 1, 1, 15, 11));
    vecs.push_back(mk(0,  118,  18, 5, 0, 0, 0, 0, 0, 1,  0,  0));
    vecs.push_back(mk(0,  120,   0, 6, 0, 0, 1, 0, 1, 1,  0,  0));
    vecs.push_back(mk(0,  139,  19, 6, 0, 0, 0, 1, 0, 1,  0,  0));
    vecs.push_back(mk(0,  142,   2, 7, 0, 0, 0, 1, 1, 1,  0,  0));
    vecs.push_back(mk(0,  143,   3, 7, 0, 0, 0, 1, 1, 0,  0,  0));
    vecs.push_back(mk(0,  179,  19, 8, 0, 0, 0, 1, 0, 0,  0,  0));
    vecs.push_back(mk(0,  183,   3, 9, 0, 0, 0, 1, 1, 1,  0,  0));
    vecs.push_back(mk(0,  200,   0, 0, 1, 1, 0, 1, 1, 1,  0,  0));
    vecs.push_back(mk(0,  203,   3, 0, 1, 0, 0, 1, 1, 1, 15,  0));
    vecs.push_back(mk(1,  642, 642, 0, 0, 0, 0, 0, 1, 1, 15, 15));
    vecs.push_back(mk(1,  643, 643, 0, 0, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(1,  658, 658, 0, 0, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(1,  659, 659, 0, 0, 0, 0, 0, 0, 1,  0,  0));
    vecs.push_back(mk(1,  754, 754, 0, 0, 0, 0, 0, 0, 1,  0,  0));
    vecs.push_back(mk(1,  755, 755, 0, 0, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(1,  800,   0, 1, 1, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(1, 1458, 658, 1, 0, 0, 0, 0, 1, 1,  0,  0));
    vecs.push_back(mk(1, 1459, 659, 1, 0, 0, 0, 0, 0, 1,  0,  0));

    // Reset held for 5 cycles; outputs checked while still in reset.
    repeat (5) @(negedge clk);
    #1;
    chk("rst_hs", -1, 32'(s_hs), 1);
    chk("rst_vs", -1, 32'(s_vs), 1);
    chk("rst_red", -1, 32'(s_r), 0);
    chk("rst_col", -1, 32'(s_col), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cur = 0;

    foreach (vecs[i]) begin
      while (cur < vecs[i].k) step();
      if (!vecs[i].dflt) begin
        chk("s_col", cur, 32'(s_col), vecs[i].col);
        chk("s_row", cur, 32'(s_row), vecs[i].row);
        chk("s_active", cur, 32'(s_act), 32'(vecs[i].act));
        chk("s_frame_start", cur, 32'(s_fs), 32'(vecs[i].fs));
        chk("s_frame_tick", cur, 32'(s_ft), 32'(vecs[i].ft));
        chk("s_frame_count", cur, 32'(s_fc), vecs[i].fc);
        chk("s_hsync", cur, 32'(s_hs), 32'(vecs[i].hs));
        chk("s_vsync", cur, 32'(s_vs), 32'(vecs[i].vs));
        chk("s_red", cur, 32'(s_r), vecs[i].red);
        chk("s_grn", cur, 32'(s_g), vecs[i].grn);
      end else begin
        chk("d_col", cur, 32'(d_col), vecs[i].col);
        chk("d_row", cur, 32'(d_row), vecs[i].row);
        chk("d_active", cur, 32'(d_act), 32'(vecs[i].act));
        chk("d_frame_start", cur, 32'(d_fs), 32'(vecs[i].fs));
        chk("d_frame_tick", cur, 32'(d_ft), 32'(vecs[i].ft));
        chk("d_frame_count", cur, 32'(d_fc), vecs[i].fc);
        chk("d_hsync", cur, 32'(d_hs), 32'(vecs[i].hs));
        chk("d_vsync", cur, 32'(d_vs), 32'(vecs[i].vs));
        chk("d_red", cur, 32'(d_r), vecs[i].red);
        chk("d_grn", cur, 32'(d_g), vecs[i].grn);
        chk("d_blu", cur, 32'(d_b), 0);
      end
    end

    // One full small frame: per-pixel alignment/blanking plus per-frame counts.
    hs_lo = 0; vs_lo = 0; red_on = 0; fs_n = 0; ft_n = 0; fs_k = 0; ft_k = 0;
    falls = 0; fall0 = 0; fall1 = 0;
    prev_hs = s_hs;
    for (int i = 0; i < 200; i++) begin
      step();
      pk = cur - 3;
      pc = pk % 20;
      pr = (pk / 20) % 10;
      pa = (pc < 12) && (pr < 6);
      chk("align_red", cur, 32'(s_r), pa ? 15 : 0);
      chk("align_grn", cur, 32'(s_g), pa ? (pc % 16) : 0);
      chk("align_blu", cur, 32'(s_b), pa ? (pr % 16) : 0);
      if (!s_hs) hs_lo++;
      if (!s_vs) vs_lo++;
      if (s_r == 4'hF) red_on++;
      if (s_fs) begin fs_n++; fs_k = cur; end
      if (s_ft) begin ft_n++; ft_k = cur; end
      if (prev_hs && !s_hs) begin
        if (falls == 0) fall0 = cur;
        if (falls == 1) fall1 = cur;
        falls++;
      end
      prev_hs = s_hs;
    end
    chk("hsync_low_cycles", cur, hs_lo, 30);
    chk("hsync_falls", cur, falls, 10);
    chk("hsync_period", cur, fall1 - fall0, 20);
    chk("vsync_low_cycles", cur, vs_lo, 40);
    chk("active_pixels", cur, red_on, 72);
    chk("frame_start_count", cur, fs_n, 1);
    chk("frame_tick_count", cur, ft_n, 1);
    chk("tick_to_start", cur, (fs_k - ft_k + 200) % 200, 80);

    // 257th tick lands at k = 120 + 256*200; count wraps 255 -> 0 -> 1.
    while (cur < 51320) step();
    chk("wrap_tick", cur, 32'(s_ft), 1);
    chk("wrap_count_before", cur, 32'(s_fc), 0);
    step();
    chk("wrap_count_after", cur, 32'(s_fc), 1);

    // Mid-frame reset at row 3 of the next frame.
    while (cur < 51465) step();
    chk("pre_rst_row", cur, 32'(s_row), 3);
    chk("pre_rst_col", cur, 32'(s_col), 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_col", cur, 32'(s_col), 0);
    chk("mid_rst_row", cur, 32'(s_row), 0);
    chk("mid_rst_count", cur, 32'(s_fc), 0);
    chk("mid_rst_start", cur, 32'(s_fs), 1);
    chk("mid_rst_active", cur, 32'(s_act), 1);
    chk("mid_rst_hs", cur, 32'(s_hs), 1);
    chk("mid_rst_vs", cur, 32'(s_vs), 1);
    chk("mid_rst_red", cur, 32'(s_r), 0);
    chk("mid_rst_d_col", cur, 32'(d_col), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("held_rst_col", cur, 32'(s_col), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cur = 0;
    chk("restart_col", cur, 32'(s_col), 0);
    chk("restart_start", cur, 32'(s_fs), 1);
    step();
    chk("restart_col1", cur, 32'(s_col), 1);
    chk("restart_start1", cur, 32'(s_fs), 0);
    while (cur < 120) step();
    chk("restart_tick", cur, 32'(s_ft), 1);
    chk("restart_count", cur, 32'(s_fc), 0);
    step();
    chk("restart_count1", cur, 32'(s_fc), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
